dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported data_memory block.
- Port 0 is the CPU load/store stage; port 1 is the loader/debug port.
- Serialises requests round-robin, holds MemRead/MemWrite for a fixed access window, and returns read data with a one-cycle acknowledge.
- Rejects misaligned word addresses without touching memory.

Parameters:
- ADDR_W, 32, address width in bytes.
- DATA_W, 32, data word width.
- MEM_LATENCY, 2, cycles the memory strobe is held per access (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  ADDR_W  port 0 byte address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  port 0 one-cycle completion pulse.
- req1, we1, addr1, wdata1, ack1  same as port 0, for port 1.
- rdata  output  DATA_W  read data; valid while ack0 or ack1 is high.
- err  output  1  high with ack when the address was misaligned.
- mem_addr  output  ADDR_W  to data_memory addr.
- mem_read  output  1  to data_memory MemRead.
- mem_write  output  1  to data_memory MemWrite.
- mem_wdata  output  DATA_W  to data_memory writedata.
- mem_rdata  input  DATA_W  from data_memory readdata.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0.
  - last_grant=1, so port 0 wins the first tie.
  - An access in progress is aborted immediately; mem_read/mem_write fall without waiting for clk.
  - No ack is issued for an aborted request.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If no req, stay.
  - If only one req is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - On the granting edge, latch granted id, we, addr and wdata into internal registers; set last_grant=id.
  - If latched addr[1:0]!=0, go to DONE with err_flag=1 and no memory strobe.
  - Otherwise go to ACCESS with cnt=MEM_LATENCY-1.
- ACCESS:
  - mem_addr/mem_wdata are driven from the latched registers and stay stable for the whole state.
  - mem_read=~we_l and mem_write=we_l, both registered outputs.
  - Each edge: if cnt!=0, cnt decrements.
  - If cnt==0: on a read, capture mem_rdata into rdata; go to DONE; strobes drop on that same edge.
- DONE:
  - Exactly one cycle.
  - ack of the granted port=1; err=err_flag; rdata holds the captured value (0 for writes and for errors).
  - Next edge: ack=0, err=0, state=IDLE.
- Latency:
  - Request sampled at edge E0; strobe high from E0 to E(MEM_LATENCY); ack high from E(MEM_LATENCY) to E(MEM_LATENCY+1).
  - With the default, ack appears after 3 edges.
  - Misaligned request: ack+err after 1 edge.
- Re-arbitration:
  - The earliest new grant is the edge after DONE (IDLE is always visited for at least one cycle).
  - A requester still holding req in that IDLE cycle is re-arbitrated.
  - Under continuous contention, ports alternate strictly.
- Request changes:
  - Requests may change while not granted.
  - Changes to addr/we/wdata after the granting edge are ignored.
  - A req dropped during ACCESS does not cancel the access; ack is still pulsed.
- rdata retains its last value outside DONE; the bench checks it only while ack is high.
- Addresses pass to memory unmodified (byte address); data_memory performs the word indexing.
- busy=1 in ACCESS and DONE.

Test Plan:
1. Port 0 read, addr=16, memory word 4 preloaded to 7, MEM_LATENCY=2 -> mem_read high for exactly 2 cycles, ack0 after 3rd edge, rdata=7, err=0, ack1 never asserted.
2. Port 1 write addr=16 data=97, then port 0 read addr=16 -> mem_write pulse 2 cycles with mem_wdata=97; the later read returns rdata=97 with ack0.
3. req0 and req1 both raised at the same edge and held, both reads, after reset -> port 0 served first, then port 1. Next pair of requests: order 0,1,0,1 continues with ack pulses 4 cycles apart.
4. Port 0 read addr=18 (misaligned) -> no mem_read/mem_write ever high; ack0 and err=1 one cycle after the request edge; rdata=0.
5. rst driven low mid-ACCESS of a port 1 write -> mem_write falls immediately without a clock edge, no ack1. After rst returns high with req0 pending, port 0 is granted first.
6. req0 dropped one cycle into ACCESS -> access completes, ack0 still pulses, and the arbiter returns to IDLE with busy=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin sequencer in front of the
// single-ported data_memory; one access at a time, one-cycle ack.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef struct packed {
    logic              id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t            state, state_n;
  req_t              lat, lat_n;
  req_t              pick;
  logic              last_grant, last_grant_n;
  logic              gnt;
  logic [3:0]        cnt, cnt_n;
  logic              err_flag, err_flag_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              rd_q, rd_n;
  logic              wr_q, wr_n;
  logic              ack0_q, ack0_n;
  logic              ack1_q, ack1_n;
  logic              err_q, err_n;

  // Tie goes to the port that did not win last time.
  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) gnt = ~last_grant;
    else              gnt = req1;
  end

  always_comb begin
    pick.id    = gnt;
    pick.we    = gnt ? we1    : we0;
    pick.addr  = gnt ? addr1  : addr0;
    pick.wdata = gnt ? wdata1 : wdata0;
  end

  always_comb begin
    state_n      = state;
    lat_n        = lat;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    err_flag_n   = err_flag;
    rdata_n      = rdata_q;
    rd_n         = 1'b0;
    wr_n         = 1'b0;
    ack0_n       = 1'b0;
    ack1_n       = 1'b0;
    err_n        = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          lat_n        = pick;
          last_grant_n = gnt;
          if (pick.addr[1:0] != 2'b00) begin
            err_flag_n = 1'b1;
            rdata_n    = '0;
            ack0_n     = ~gnt;
            ack1_n     = gnt;
            err_n      = 1'b1;
            state_n    = DONE;
          end else begin
            err_flag_n = 1'b0;
            cnt_n      = CNT_INIT;
            rd_n       = ~pick.we;
            wr_n       = pick.we;
            state_n    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
          rd_n  = ~lat.we;
          wr_n  = lat.we;
        end else begin
          rdata_n = lat.we ? '0 : mem_rdata;
          ack0_n  = ~lat.id;
          ack1_n  = lat.id;
          err_n   = err_flag;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Reset drops strobes at once, aborting any access without an ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lat        <= '0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      err_flag   <= 1'b0;
      rdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      lat        <= lat_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
      err_flag   <= err_flag_n;
      rdata_q    <= rdata_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      ack0_q     <= ack0_n;
      ack1_q     <= ack1_n;
      err_q      <= err_n;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = lat.addr;
  assign mem_wdata = lat.wdata;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: cycle vectors plus hand sequences for
// async reset abort and tie-break after reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 0, we0 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0;
  logic        req1 = 0, we1 = 0;
  logic [31:0] addr1 = 0, wdata1 = 0;
  logic        ack0, ack1, err, busy;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:15];

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0),
    .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1),
    .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk)
    if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        k0, k1, ke, kb, kr, kw;
    logic [31:0] krd, kma, kwd;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic r0, w0, input logic [31:0] a0, d0,
    input logic r1, w1, input logic [31:0] a1, d1,
    input logic k0, k1, ke, kb, kr, kw,
    input logic [31:0] krd, kma, kwd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.k0 = k0; v.k1 = k1; v.ke = ke;
    v.kb = kb; v.kr = kr; v.kw = kw;
    v.krd = krd; v.kma = kma; v.kwd = kwd;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[4] = 32'd7;
    mem[5] = 32'd33;

    // both held: 0,1,0,1
    for (int p = 0; p < 2; p++) begin
      add(1,0,16,0, 1,0,20,0, 0,0,0,1,1,0, 0,16,0);
      add(1,0,16,0, 1,0,20,0, 0,0,0,1,1,0, 0,16,0);
      add(1,0,16,0, 1,0,20,0, 1,0,0,1,0,0, 7,0,0);
      add(1,0,16,0, 1,0,20,0, 0,0,0,0,0,0, 0,0,0);
      add(1,0,16,0, 1,0,20,0, 0,0,0,1,1,0, 0,20,0);
      add(1,0,16,0, 1,0,20,0, 0,0,0,1,1,0, 0,20,0);
      add(1,0,16,0, 1,0,20,0, 0,1,0,1,0,0, 33,0,0);
      add(0,0,16,0, 0,0,20,0, 0,0,0,0,0,0, 0,0,0);
    end
    // single port 0 read of word 4
    add(1,0,16,0, 0,0,0,0, 0,0,0,1,1,0, 0,16,0);
    add(1,0,16,0, 0,0,0,0, 0,0,0,1,1,0, 0,16,0);
    add(1,0,16,0, 0,0,0,0, 1,0,0,1,0,0, 7,0,0);
    add(0,0,16,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0);
    // port 1 write 97, then port 0 reads it back
    add(0,0,0,0, 1,1,16,97, 0,0,0,1,0,1, 0,16,97);
    add(0,0,0,0, 1,1,16,97, 0,0,0,1,0,1, 0,16,97);
    add(0,0,0,0, 1,1,16,97, 0,1,0,1,0,0, 0,0,0);
    add(0,0,0,0, 0,0,0,0,   0,0,0,0,0,0, 0,0,0);
    add(1,0,16,0, 0,0,0,0, 0,0,0,1,1,0, 0,16,0);
    add(1,0,16,0, 0,0,0,0, 0,0,0,1,1,0, 0,16,0);
    add(1,0,16,0, 0,0,0,0, 1,0,0,1,0,0, 97,0,0);
    add(0,0,16,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0);
    // misaligned: ack+err one edge later
    add(1,0,18,0, 0,0,0,0, 1,0,1,1,0,0, 0,0,0);
    add(0,0,18,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0);
    // req0 dropped mid-access, addr change ignored
    add(1,0,20,0, 0,0,0,0, 0,0,0,1,1,0, 0,20,0);
    add(0,0,16,0, 0,0,0,0, 0,0,0,1,1,0, 0,20,0);
    add(0,0,16,0, 0,0,0,0, 1,0,0,1,0,0, 33,0,0);
    add(0,0,16,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0);

    #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mrd", mem_read, 0);
    chk("rst_mwr", mem_write, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      req0 = vq[i].r0; we0 = vq[i].w0;
      addr0 = vq[i].a0; wdata0 = vq[i].d0;
      req1 = vq[i].r1; we1 = vq[i].w1;
      addr1 = vq[i].a1; wdata1 = vq[i].d1;
      cyc();
      chk($sformatf("v%0d_ack0", i), ack0, vq[i].k0);
      chk($sformatf("v%0d_ack1", i), ack1, vq[i].k1);
      chk($sformatf("v%0d_err", i), err, vq[i].ke);
      chk($sformatf("v%0d_busy", i), busy, vq[i].kb);
      chk($sformatf("v%0d_mrd", i), mem_read, vq[i].kr);
      chk($sformatf("v%0d_mwr", i), mem_write, vq[i].kw);
      if (vq[i].k0 || vq[i].k1)
        chk($sformatf("v%0d_rdata", i), rdata, vq[i].krd);
      if (vq[i].kr || vq[i].kw)
        chk($sformatf("v%0d_maddr", i), mem_addr, vq[i].kma);
      if (vq[i].kw)
        chk($sformatf("v%0d_mwdata", i), mem_wdata, vq[i].kwd);
    end

    // async reset in the middle of a port 1 write
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 24; wdata1 = 5;
    cyc();
    chk("ab_mwr_on", mem_write, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ab_mwr_off", mem_write, 0);
    chk("ab_busy", busy, 0);
    req0 = 1; we0 = 0; addr0 = 16;
    repeat (3) begin
      cyc();
      chk("ab_no_ack1", ack1, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("ar_mrd", mem_read, 1);
    chk("ar_maddr", mem_addr, 16);
    cyc();
    cyc();
    chk("ar_ack0", ack0, 1);
    chk("ar_ack1", ack1, 0);
    chk("ar_rdata", rdata, 97);
    @(negedge clk);
    req0 = 0;
    cyc();
    chk("ar_idle", busy, 0);
    cyc();
    chk("ar_p1_mwr", mem_write, 1);
    chk("ar_p1_maddr", mem_addr, 24);
    cyc();
    cyc();
    chk("ar_p1_ack1", ack1, 1);
    chk("ar_p1_err", err, 0);
    @(negedge clk);
    req1 = 0;
    cyc();
    chk("ar_end_busy", busy, 0);
    chk("ar_mem6", mem[6], 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
